// File: rtl/debouncer.sv
// debouncer: conditions a raw, bouncing push-button level into a clean,
// registered level in the clk domain. The raw input passes through a
// two-flop synchronizer. The output asserts only after the synchronized level
// has stayed high for COUNT_MAX consecutive cycles. Any low cycle that reaches
// the synchronizer output drops the output on the next edge, so release is
// not delayed by the debounce window.
module debouncer #(
    parameter int COUNT_MAX = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic button_in,
    output logic button_out
);

    // The counter must be able to hold COUNT_MAX itself, because it saturates there.
    localparam int CW = $clog2(COUNT_MAX + 1);
    localparam logic [CW-1:0] CNT_TOP  = CW'(COUNT_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(COUNT_MAX - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          btn_q;

    // Two-flop synchronizer. Only sync2 is used downstream; button_in never is.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= button_in;
            sync2 <= sync1;
        end
    end

    // Stable-high counter with a registered output. A single low cycle clears
    // the run. The output rises on the same edge where the count reaches
    // COUNT_MAX. The counter then saturates and never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            btn_q <= 1'b0;
        end else if (!sync2) begin
            cnt   <= '0;
            btn_q <= 1'b0;
        end else if (cnt < CNT_TOP) begin
            cnt <= cnt + CNT_ONE;
            if (cnt == CNT_LAST) begin
                btn_q <= 1'b1;
            end
        end else begin
            btn_q <= 1'b1;
        end
    end

    assign button_out = btn_q;

endmodule

// File: tb/tb_debouncer.sv
// tb_debouncer: bench for debouncer with COUNT_MAX=8. A second instance with
// COUNT_MAX=1 shares the same stimulus and is checked only in its own sequence.
// Each vector gives the reset and button_in values applied before a rising edge,
// together with the button_out value required just after that edge.
module tb_debouncer;

    typedef struct {
        logic rst;
        logic bin;
        logic exp;
    } vec_t;

    logic clk;
    logic rst;
    logic bin;
    logic out8;
    logic out1;

    vec_t       vecs[$];
    logic [0:0] exp_q[$];
    int         n_vec;
    int         n_err;

    debouncer #(.COUNT_MAX(8)) dut (
        .clk        (clk),
        .reset      (rst),
        .button_in  (bin),
        .button_out (out8)
    );

    debouncer #(.COUNT_MAX(1)) dut1 (
        .clk        (clk),
        .reset      (rst),
        .button_in  (bin),
        .button_out (out1)
    );

    // Clock and reset: 10 ns period. Reset is held from time zero until the table drives it.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst = 1'b1;
        bin = 1'b0;
    end

    // Watchdog timer, so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic add(input logic r, input logic b, input logic e);
        vec_t v;
        v.rst = r;
        v.bin = b;
        v.exp = e;
        vecs.push_back(v);
    endtask

    // Press held for n edges. The output rises at edge 10 of the press.
    task automatic add_press(input int n);
        for (int k = 1; k <= n; k++) add(1'b0, 1'b1, (k >= 10));
    endtask

    // Release held for n edges, starting from button_out=1. The output is low from edge 3.
    task automatic add_release(input int n);
        for (int k = 1; k <= n; k++) add(1'b0, 1'b0, (k < 3));
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: applies one vector before a rising edge and pushes its expected output.
    task automatic drive(input vec_t v);
        @(negedge clk);
        rst = v.rst;
        bin = v.bin;
        exp_q.push_back(v.exp);
    endtask

    // Scoreboard: pops the expected output and compares it just after the rising edge.
    task automatic sample(input int idx);
        logic [0:0] e;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check($sformatf("vec%0d", idx), out8, e[0]);
    endtask

    initial begin
        pattern_build();
        n_vec = 0;
        n_err = 0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            sample(i);
        end

        // Asynchronous reset while button_out=1 clears the output before any edge.
        check("pre_async_reset", out8, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_reset_now", out8, 1'b0);
        check("async_reset_now_cm1", out1, 1'b0);
        @(posedge clk);
        #1;
        check("async_reset_edge", out8, 1'b0);

        // COUNT_MAX=1: the output rises at edge 3 and falls at edge 3 after release.
        @(negedge clk);
        rst = 1'b0;
        bin = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("cm1_press_e%0d", k), out1, (k >= 3));
        end
        @(negedge clk);
        bin = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("cm1_release_e%0d", k), out1, (k < 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Vector table for COUNT_MAX=8.
    task automatic pattern_build();
        logic [6:0] bounce;
        // Reset held with the button high, then released with the button still high.
        for (int k = 0; k < 3; k++) add(1'b1, 1'b1, 1'b0);
        add_press(12);
        add_release(5);
        // Clean press held for 20 edges, which also exercises saturation.
        add_press(20);
        add_release(5);
        add_press(10);
        add_release(5);
        // Bouncing press 1,1,1,0,1,1,0, then steady high. The output rises 10 edges into the steady run.
        bounce = 7'b1110110;
        for (int j = 0; j < 7; j++) add(1'b0, bounce[6-j], 1'b0);
        add_press(14);
        add_release(5);
        // Short press of 7 edges never asserts the output.
        for (int k = 0; k < 7; k++) add(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) add(1'b0, 1'b0, 1'b0);
        // Reset mid-count: press for 5 edges, reset for 2, then a fresh full run is needed.
        for (int k = 0; k < 5; k++) add(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) add(1'b1, 1'b1, 1'b0);
        add_press(12);
        // Single-cycle glitch while the output is high drops the output; re-arming needs a full run.
        add(1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 12; k++) add(1'b0, 1'b1, (k == 1) || (k >= 10));
    endtask

endmodule
